// File: rtl/ddr3_arbiter_pkg.sv
// Shared types, constants and width helpers for the two-port DDR3 request arbiter.
package ddr3_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StIssue    = 2'd1,
        StWaitRead = 2'd2,
        StResp     = 2'd3
    } arb_state_e;

    localparam int unsigned NUM_PORTS                     = 2;
    localparam int unsigned PORT_IDX_W                    = $clog2(NUM_PORTS);
    localparam int unsigned DEFAULT_ADDRESS_BITWIDTH      = 15;
    localparam int unsigned DEFAULT_BANK_ADDRESS_BITWIDTH = 3;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    // Requesters address the part as {bank, row/column}.
    function automatic int unsigned full_addr_width(input int unsigned bank_w,
                                                    input int unsigned addr_w);
        return bank_w + addr_w;
    endfunction

    // One spare bit so the read-wait counter can never wrap before the timeout compare.
    function automatic int unsigned timeout_cnt_width(input int unsigned timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/round_robin_arbiter_2.sv
// Two-requester round-robin pick; the previous winner is held by the parent.
module round_robin_arbiter_2
    import ddr3_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last_grant,
    output logic       grant_valid,
    output port_idx_t  grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        unique case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/ddr3_request_arbiter.sv
// Two-port round-robin request sequencer in front of the DDR3 controller user interface.
// One command is in flight at a time; its completion is routed back to the owning port.
module ddr3_request_arbiter
    import ddr3_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_BITWIDTH      = DEFAULT_ADDRESS_BITWIDTH,
    parameter int unsigned BANK_ADDRESS_BITWIDTH = DEFAULT_BANK_ADDRESS_BITWIDTH,
    parameter int unsigned DQ_BITWIDTH           = 16,
    parameter int unsigned READ_TIMEOUT          = 1024,
    localparam int unsigned AW = full_addr_width(BANK_ADDRESS_BITWIDTH, ADDRESS_BITWIDTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic                   p0_req_valid,
    output logic                   p0_req_ready,
    input  logic                   p0_req_write,
    input  logic [AW-1:0]          p0_req_address,
    input  logic [DQ_BITWIDTH-1:0] p0_req_wdata,
    output logic                   p0_rsp_valid,
    output logic [DQ_BITWIDTH-1:0] p0_rsp_rdata,
    output logic                   p0_rsp_error,

    input  logic                   p1_req_valid,
    output logic                   p1_req_ready,
    input  logic                   p1_req_write,
    input  logic [AW-1:0]          p1_req_address,
    input  logic [DQ_BITWIDTH-1:0] p1_req_wdata,
    output logic                   p1_rsp_valid,
    output logic [DQ_BITWIDTH-1:0] p1_rsp_rdata,
    output logic                   p1_rsp_error,

    output logic                   write_enable,
    output logic                   read_enable,
    output logic [AW-1:0]          i_user_data_address,
    output logic [DQ_BITWIDTH-1:0] i_user_data,
    input  logic                   ctrl_ready,
    input  logic                   ctrl_read_valid,
    input  logic [DQ_BITWIDTH-1:0] o_user_data
);

    localparam int unsigned    CW           = timeout_cnt_width(READ_TIMEOUT);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(READ_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    arb_state_e             r_state;
    arb_state_e             w_state_next;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_count_next;
    logic [DQ_BITWIDTH-1:0] r_rdata;
    logic [DQ_BITWIDTH-1:0] w_rdata_next;
    logic                   r_error;
    logic                   w_error_next;

    port_idx_t              r_last_grant;
    port_idx_t              r_port;
    logic                   r_write;
    logic [AW-1:0]          r_addr;
    logic [DQ_BITWIDTH-1:0] r_wdata;

    logic                   w_grant_valid;
    port_idx_t              w_grant_idx;
    logic                   w_accept;
    logic                   w_sel_write;
    logic [AW-1:0]          w_sel_addr;
    logic [DQ_BITWIDTH-1:0] w_sel_wdata;
    logic                   w_resp;

    round_robin_arbiter_2 u_rr_arbiter (
        .req         ({p1_req_valid, p0_req_valid}),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // reset_n gating keeps ready low during reset even before the first reset edge.
    assign w_accept     = reset_n & (r_state == StIdle) & w_grant_valid;
    assign p0_req_ready = w_accept & (w_grant_idx == 1'b0);
    assign p1_req_ready = w_accept & (w_grant_idx == 1'b1);

    always_comb begin
        w_sel_write = p0_req_write;
        w_sel_addr  = p0_req_address;
        w_sel_wdata = p0_req_wdata;
        if (w_grant_idx == 1'b1) begin
            w_sel_write = p1_req_write;
            w_sel_addr  = p1_req_address;
            w_sel_wdata = p1_req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_idx;
            r_port       <= w_grant_idx;
            r_write      <= w_sel_write;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_count <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_rdata <= w_rdata_next;
            r_error <= w_error_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_rdata_next = r_rdata;
        w_error_next = r_error;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                if (ctrl_ready) begin
                    w_state_next = r_write ? StResp : StWaitRead;
                    w_count_next = '0;
                    w_rdata_next = '0;
                    w_error_next = 1'b0;
                end
            end
            StWaitRead: begin
                // Data arriving on the last allowed cycle still beats the timeout.
                if (ctrl_read_valid) begin
                    w_state_next = StResp;
                    w_rdata_next = o_user_data;
                    w_error_next = 1'b0;
                end else if (r_count == TIMEOUT_LAST) begin
                    w_state_next = StResp;
                    w_rdata_next = '0;
                    w_error_next = 1'b1;
                end else begin
                    w_count_next = r_count + CNT_ONE;
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign write_enable        = (r_state == StIssue) & r_write;
    assign read_enable         = (r_state == StIssue) & ~r_write;
    assign i_user_data_address = r_addr;
    assign i_user_data         = r_wdata;

    assign w_resp       = reset_n & (r_state == StResp);
    assign p0_rsp_valid = w_resp & (r_port == 1'b0);
    assign p1_rsp_valid = w_resp & (r_port == 1'b1);
    assign p0_rsp_rdata = p0_rsp_valid ? r_rdata : '0;
    assign p1_rsp_rdata = p1_rsp_valid ? r_rdata : '0;
    assign p0_rsp_error = p0_rsp_valid & r_error;
    assign p1_rsp_error = p1_rsp_valid & r_error;

endmodule

// File: tb/tb_ddr3_request_arbiter.sv
// Scoreboard bench for ddr3_request_arbiter with a small read-data responder model.
module tb_ddr3_request_arbiter;

    localparam int unsigned AW = 15;
    localparam int unsigned BW = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 8;
    localparam int unsigned FW = AW + BW;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    logic          clk;
    logic          reset_n;
    logic          p0_req_valid, p0_req_ready, p0_req_write;
    logic [FW-1:0] p0_req_address;
    logic [DW-1:0] p0_req_wdata;
    logic          p0_rsp_valid, p0_rsp_error;
    logic [DW-1:0] p0_rsp_rdata;
    logic          p1_req_valid, p1_req_ready, p1_req_write;
    logic [FW-1:0] p1_req_address;
    logic [DW-1:0] p1_req_wdata;
    logic          p1_rsp_valid, p1_rsp_error;
    logic [DW-1:0] p1_rsp_rdata;
    logic          write_enable, read_enable;
    logic [FW-1:0] i_user_data_address;
    logic [DW-1:0] i_user_data;
    logic          ctrl_ready, ctrl_read_valid;
    logic [DW-1:0] o_user_data;
    logic          any_out;

    rsp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic rd_en   = 1'b0;
    int   rd_lat  = 4;
    int   m_rd_cnt = 0;
    logic m_last   = 1'b1;

    ddr3_request_arbiter #(
        .ADDRESS_BITWIDTH      (AW),
        .BANK_ADDRESS_BITWIDTH (BW),
        .DQ_BITWIDTH           (DW),
        .READ_TIMEOUT          (TO)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .p0_req_valid        (p0_req_valid),
        .p0_req_ready        (p0_req_ready),
        .p0_req_write        (p0_req_write),
        .p0_req_address      (p0_req_address),
        .p0_req_wdata        (p0_req_wdata),
        .p0_rsp_valid        (p0_rsp_valid),
        .p0_rsp_rdata        (p0_rsp_rdata),
        .p0_rsp_error        (p0_rsp_error),
        .p1_req_valid        (p1_req_valid),
        .p1_req_ready        (p1_req_ready),
        .p1_req_write        (p1_req_write),
        .p1_req_address      (p1_req_address),
        .p1_req_wdata        (p1_req_wdata),
        .p1_rsp_valid        (p1_rsp_valid),
        .p1_rsp_rdata        (p1_rsp_rdata),
        .p1_rsp_error        (p1_rsp_error),
        .write_enable        (write_enable),
        .read_enable         (read_enable),
        .i_user_data_address (i_user_data_address),
        .i_user_data         (i_user_data),
        .ctrl_ready          (ctrl_ready),
        .ctrl_read_valid     (ctrl_read_valid),
        .o_user_data         (o_user_data)
    );

    assign any_out = p0_req_ready | p1_req_ready | p0_rsp_valid | p1_rsp_valid |
                     p0_rsp_error | p1_rsp_error | write_enable | read_enable |
                     (|p0_rsp_rdata) | (|p1_rsp_rdata) | (|i_user_data_address) |
                     (|i_user_data);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Controller read model: data = running count, rd_lat cycles after the accepted read.
    initial begin : responder
        int rd_cnt;
        rd_cnt          = 0;
        ctrl_read_valid = 1'b0;
        o_user_data     = '0;
        forever begin
            @(negedge clk);
            if (rd_en && read_enable && ctrl_ready) begin
                @(posedge clk);
                repeat (rd_lat - 1) @(posedge clk);
                #1;
                rd_cnt++;
                ctrl_read_valid = 1'b1;
                o_user_data     = DW'(rd_cnt);
                @(posedge clk);
                #1;
                ctrl_read_valid = 1'b0;
                o_user_data     = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_exp(input logic port, input logic [DW-1:0] data, input logic err);
        rsp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic get_rsp(input int max_cycles, output logic found, output rsp_t obs,
                           output logic both);
        found = 1'b0;
        both  = 1'b0;
        obs   = '0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            @(negedge clk);
            if (p0_rsp_valid || p1_rsp_valid) begin
                found    = 1'b1;
                both     = p0_rsp_valid && p1_rsp_valid;
                obs.port = p1_rsp_valid;
                obs.data = p1_rsp_valid ? p1_rsp_rdata : p0_rsp_rdata;
                obs.err  = p1_rsp_valid ? p1_rsp_error : p0_rsp_error;
            end
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        p0_req_valid = 1'b1;
        p1_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (any_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: some output nonzero, got any=%b want 0",
                         i, any_out);
            end
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({p1_req_ready, p0_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_tie: ready{p1,p0} got %b want 01",
                     {p1_req_ready, p0_req_ready});
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
    endtask

    task automatic test_contention();
        logic found, both, got, exp_port;
        rsp_t obs, exp;
        rd_en      = 1'b1;
        rd_lat     = 4;
        ctrl_ready = 1'b1;
        @(posedge clk);
        #1;
        p0_req_write = 1'b0; p0_req_address = 18'h00100; p0_req_valid = 1'b1;
        p1_req_write = 1'b0; p1_req_address = 18'h00200; p1_req_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_port = ~m_last;
            m_rd_cnt++;
            push_exp(exp_port, DW'(m_rd_cnt), 1'b0);
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (p0_req_ready || p1_req_ready) got = 1'b1;
            end
            n_tests++;
            if (!got || {p1_req_ready, p0_req_ready} !== (exp_port ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL contention_grant %0d: ready{p1,p0} got %b want port %0d",
                         t, {p1_req_ready, p0_req_ready}, exp_port);
            end
            m_last = exp_port;
            @(posedge clk);
            #1;
            if (exp_port) p1_req_address = p1_req_address + 1'b1;
            else          p0_req_address = p0_req_address + 1'b1;
            get_rsp(6, found, obs, both);
            exp = sb.pop_front();
            n_tests++;
            if (!found || both || obs !== exp) begin
                n_fail++;
                $display("FAIL contention_rsp %0d: got found=%b both=%b port=%0d data=%h err=%b want port=%0d data=%h err=%b",
                         t, found, both, obs.port, obs.data, obs.err, exp.port, exp.data, exp.err);
            end
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
    endtask

    task automatic test_single_write();
        logic found, both;
        rsp_t obs, exp;
        ctrl_ready = 1'b1;
        @(posedge clk);
        #1;
        p0_req_write = 1'b1; p0_req_address = 18'h12345; p0_req_wdata = 16'hBEEF;
        p0_req_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({p1_req_ready, p0_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL write_ready: ready{p1,p0} got %b want 01", {p1_req_ready, p0_req_ready});
        end
        m_last = 1'b0;
        push_exp(1'b0, 16'h0000, 1'b0);
        @(posedge clk);
        #1 p0_req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({write_enable, read_enable} !== 2'b10 || i_user_data_address !== 18'h12345 ||
            i_user_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL write_issue: got we/re=%b addr=%h data=%h want 10 12345 beef",
                     {write_enable, read_enable}, i_user_data_address, i_user_data);
        end
        get_rsp(1, found, obs, both);
        exp = sb.pop_front();
        n_tests++;
        if (!found || both || obs !== exp || write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL write_rsp: got found=%b we=%b port=%0d data=%h err=%b want port=%0d data=%h err=%b",
                     found, write_enable, obs.port, obs.data, obs.err, exp.port, exp.data, exp.err);
        end
    endtask

    task automatic test_backpressure();
        logic found, both;
        rsp_t obs, exp;
        ctrl_ready = 1'b0;
        rd_en      = 1'b1;
        rd_lat     = 2;
        @(posedge clk);
        #1;
        p0_req_write = 1'b0; p0_req_address = 18'h2ABCD; p0_req_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({p1_req_ready, p0_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_ready: ready{p1,p0} got %b want 01", {p1_req_ready, p0_req_ready});
        end
        m_last = 1'b0;
        @(posedge clk);
        #1;
        p0_req_valid = 1'b0;
        p1_req_write = 1'b0; p1_req_address = 18'h00777; p1_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (read_enable !== 1'b1 || write_enable !== 1'b0 ||
                i_user_data_address !== 18'h2ABCD || p0_req_ready || p1_req_ready) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got re=%b we=%b addr=%h rdy=%b%b want 1 0 2abcd 00",
                         i, read_enable, write_enable, i_user_data_address,
                         p1_req_ready, p0_req_ready);
            end
            if (i == 4) begin
                @(posedge clk);
                #1 ctrl_ready = 1'b1;
            end
        end
        m_rd_cnt++;
        push_exp(1'b0, DW'(m_rd_cnt), 1'b0);
        get_rsp(3, found, obs, both);
        exp = sb.pop_front();
        n_tests++;
        if (!found || both || obs !== exp) begin
            n_fail++;
            $display("FAIL bp_rsp: got found=%b port=%0d data=%h err=%b want port=%0d data=%h err=%b",
                     found, obs.port, obs.data, obs.err, exp.port, exp.data, exp.err);
        end
        p1_req_valid = 1'b0;
    endtask

    task automatic test_read_timeout(input logic with_data);
        logic found, both, quiet;
        rsp_t obs, exp;
        rd_en      = with_data;
        rd_lat     = TO;
        ctrl_ready = 1'b1;
        @(posedge clk);
        #1;
        p1_req_write = 1'b0; p1_req_address = 18'h30042; p1_req_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({p1_req_ready, p0_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_ready data=%b: ready{p1,p0} got %b want 10",
                     with_data, {p1_req_ready, p0_req_ready});
        end
        m_last = 1'b1;
        @(posedge clk);
        #1 p1_req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (read_enable !== 1'b1 || i_user_data_address !== 18'h30042) begin
            n_fail++;
            $display("FAIL timeout_issue data=%b: got re=%b addr=%h want 1 30042",
                     with_data, read_enable, i_user_data_address);
        end
        if (with_data) begin
            m_rd_cnt++;
            push_exp(1'b1, DW'(m_rd_cnt), 1'b0);
        end else begin
            push_exp(1'b1, 16'h0000, 1'b1);
        end
        quiet = 1'b1;
        for (int k = 0; k < int'(TO); k++) begin
            @(negedge clk);
            if (p0_rsp_valid || p1_rsp_valid) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL timeout_early data=%b: response seen before wait cycle %0d, want none",
                     with_data, TO);
        end
        get_rsp(1, found, obs, both);
        exp = sb.pop_front();
        n_tests++;
        if (!found || both || obs !== exp) begin
            n_fail++;
            $display("FAIL timeout_rsp data=%b: got found=%b port=%0d data=%h err=%b want port=%0d data=%h err=%b",
                     with_data, found, obs.port, obs.data, obs.err, exp.port, exp.data, exp.err);
        end
    endtask

    task automatic test_midop_reset();
        logic quiet;
        rd_en      = 1'b0;
        ctrl_ready = 1'b1;
        @(posedge clk);
        #1;
        p0_req_write = 1'b0; p0_req_address = 18'h10F0F; p0_req_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({p1_req_ready, p0_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_ready: ready{p1,p0} got %b want 01", {p1_req_ready, p0_req_ready});
        end
        m_last = 1'b0;
        @(posedge clk);
        #1 p0_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (any_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: some output nonzero, got any=%b want 0", any_out);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        m_last = 1'b1;
        quiet  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (p0_rsp_valid || p1_rsp_valid || read_enable || write_enable) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL midrst_quiet: response or command after reset, want none");
        end
        @(posedge clk);
        #1;
        p0_req_valid = 1'b1;
        p1_req_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({p1_req_ready, p0_req_ready} !== (m_last ? 2'b01 : 2'b10)) begin
            n_fail++;
            $display("FAIL midrst_tie: ready{p1,p0} got %b want 01", {p1_req_ready, p0_req_ready});
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        p0_req_valid   = 1'b0;
        p0_req_write   = 1'b0;
        p0_req_address = '0;
        p0_req_wdata   = '0;
        p1_req_valid   = 1'b0;
        p1_req_write   = 1'b0;
        p1_req_address = '0;
        p1_req_wdata   = '0;
        ctrl_ready     = 1'b0;

        test_reset();
        test_contention();
        test_single_write();
        test_backpressure();
        test_read_timeout(1'b0);
        test_read_timeout(1'b1);
        test_midop_reset();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
